// File: rtl/counter_pkg.sv
// Shared BCD digit helpers and prescaler sizing for the auto counters.
// Pure combinational functions; no latency, no backpressure.
package counter_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    // flag is carry (inc), borrow (dec) or saturation (clamp)
    typedef struct packed {
        bcd_t dig;
        logic flag;
    } bcd_res_t;

    function automatic bcd_res_t bcd_inc(input bcd_t d);
        bcd_res_t r;
        r.flag = (d >= 4'd9);
        r.dig  = r.flag ? 4'd0 : d + 4'd1;
        return r;
    endfunction

    function automatic bcd_res_t bcd_dec(input bcd_t d);
        bcd_res_t r;
        r.flag = (d == 4'd0);
        r.dig  = r.flag ? 4'd9 : d - 4'd1;
        return r;
    endfunction

    function automatic bcd_res_t bcd_clamp(input bcd_t d);
        bcd_res_t r;
        r.flag = (d > 4'd9);
        r.dig  = r.flag ? 4'd9 : d;
        return r;
    endfunction

    function automatic int presc_w(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler counting 0..DIV-1 while enabled; tick_next flags the step edge combinationally.
// Restart zeroes the count on the next edge; en low freezes the count (no backpressure).
module tick_gen
    import counter_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick_next
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int W   = presc_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("tick_gen: CLK_HZ/TICK_HZ must be at least 1");
    end

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_next = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (tick_next) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/auto_counter_bcd.sv
// Multi-digit up/down BCD counter stepping on prescaled ticks, with clear, clamped load and wrap pulse.
// Outputs registered, new q/tick/tc visible one edge after the step decision; en low pauses (no backpressure).
module auto_counter_bcd
    import counter_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int DIGITS  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      clr,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    output logic [BCD_W*DIGITS-1:0]   q,
    output logic                      tick,
    output logic                      tc
);

    localparam int QW = BCD_W * DIGITS;

    logic            step;
    logic [QW-1:0]   q_q, q_d;
    logic            tick_q, tick_d;
    logic            tc_q, tc_d;
    logic [QW-1:0]   up_val, dn_val, ld_val;
    logic [DIGITS-1:0] all_nine, all_zero;

    // clr/load restart the prescaler so the next step is a full period away
    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .restart   (clr | load),
        .tick_next (step)
    );

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam logic [DIGITS-1:0] LOWER = DIGITS'((64'd1 << g) - 64'd1);

        bcd_t     d, ldv, incv, decv;
        logic     nine, zero, cin_up, cin_dn;
        bcd_res_t r;

        assign d = q_q[g*BCD_W +: BCD_W];

        always_comb begin
            r    = bcd_clamp(load_val[g*BCD_W +: BCD_W]);
            ldv  = r.dig;
            r    = bcd_inc(d);
            incv = r.dig;
            nine = r.flag;
            r    = bcd_dec(d);
            decv = r.dig;
            zero = r.flag;
        end

        assign all_nine[g] = nine;
        assign all_zero[g] = zero;

        // a digit moves only when every lower digit is at its wrap value
        assign cin_up = &(all_nine | ~LOWER);
        assign cin_dn = &(all_zero | ~LOWER);

        assign up_val[g*BCD_W +: BCD_W] = cin_up ? incv : d;
        assign dn_val[g*BCD_W +: BCD_W] = cin_dn ? decv : d;
        assign ld_val[g*BCD_W +: BCD_W] = ldv;
    end

    always_comb begin
        q_d    = q_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = ld_val;
        end else if (step) begin
            tick_d = 1'b1;
            if (up_dn) begin
                q_d  = up_val;
                tc_d = &all_nine;
            end else begin
                q_d  = dn_val;
                tc_d = &all_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            q_q    <= q_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign tc   = tc_q;

endmodule
